piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_bit_counter.sv | 32 +++
 rtl/piso_serializer.sv | 118 +++++++++++
 tb/tb_piso_serializer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Holds the FSM state encoding, default word width and counter sizing function.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int PISO_DEFAULT_WIDTH = 4;

  // A 2-bit word still needs a 1-bit counter, so never return less than 1.
  function automatic int piso_count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for piso_serializer: counts 0..WIDTH-1 and wraps.
// wrap flags the enabled cycle on which the counter returns to 0.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH,
  localparam int CW = piso_count_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  assign wrap = enable && (count == LAST_IDX);

  // clear wins over enable so a new frame always starts counting from bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with ready/valid/last framing.
// Define PISO_PARITY_EN to append an even-parity bit after each data word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             serial_out,
  output logic             valid,
  output logic             last
);

  localparam int CW = piso_count_width(WIDTH);

  piso_state_t      state;
  piso_state_t      state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             wrap;
  logic             accept;
  logic             frame_end;
  logic             data_bit;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state == SHIFT),
    .count  (count),
    .wrap   (wrap)
  );

  assign data_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

`ifdef PISO_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^data_in;
    end
  end

  assign frame_end = (state == PARITY);
`else
  assign frame_end = wrap;
`endif

  // Accepting during the final bit lets the next frame follow with no gap.
  assign ready  = (state == IDLE) || frame_end;
  assign accept = load && ready;
  assign last   = frame_end;
  assign valid  = (state != IDLE);

  always_comb begin
    serial_out = 1'b0;
    case (state)
      SHIFT:   serial_out = data_bit;
`ifdef PISO_PARITY_EN
      PARITY:  serial_out = parity_q;
`endif
      default: serial_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= data_in;
    end else if (state == SHIFT) begin
      shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (wrap) begin
`ifdef PISO_PARITY_EN
          state_next = PARITY;
`else
          state_next = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_next = accept ? SHIFT : IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=4, both bit orders).
// Expected frames include the parity bit when PISO_PARITY_EN is defined.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_a = 1'b0;
  logic [3:0] data_a = 4'b0000;
  logic       ready_a, serial_a, valid_a, last_a;
  logic       load_b = 1'b0;
  logic [3:0] data_b = 4'b0000;
  logic       ready_b, serial_b, valid_b, last_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .reset      (reset),
    .load       (load_a),
    .data_in    (data_a),
    .ready      (ready_a),
    .serial_out (serial_a),
    .valid      (valid_a),
    .last       (last_a)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .load       (load_b),
    .data_in    (data_b),
    .ready      (ready_b),
    .serial_out (serial_b),
    .valid      (valid_b),
    .last       (last_b)
  );

  task automatic test_reset();
    reset  = 1'b1;
    load_a = 1'b1;
    data_a = 4'b1111;
    repeat (3) @(negedge clk);
    tests_run++;
    if (valid_a !== 1'b0 || serial_a !== 1'b0 || last_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs valid=%b serial=%b last=%b expected 0 0 0", valid_a, serial_a, last_a);
    end
    load_a = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ready_a !== 1'b1 || valid_a !== 1'b0 || ready_b !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_release ready_a=%b ready_b=%b valid=%b expected 1 1 0", ready_a, ready_b, valid_a);
    end
  endtask

  task automatic test_single();
    bit exp_bits[$];
    exp_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
`ifdef PISO_PARITY_EN
    exp_bits.push_back(1'b1);
`endif
    load_a = 1'b1;
    data_a = 4'b1011;
    @(negedge clk);
    load_a = 1'b0;
    data_a = 4'b0000;
    for (int i = 0; i < FRAME; i++) begin
      tests_run++;
      if (valid_a !== 1'b1 || serial_a !== exp_bits[i] || last_a !== (i == FRAME - 1) ||
          ready_a !== (i == FRAME - 1)) begin
        tests_failed++;
        $display("[TB] FAIL single_bit%0d valid=%b serial=%b last=%b ready=%b expected 1 %b %b %b",
                 i, valid_a, serial_a, last_a, ready_a, exp_bits[i], (i == FRAME - 1), (i == FRAME - 1));
      end
      @(negedge clk);
    end
    tests_run++;
    if (valid_a !== 1'b0 || serial_a !== 1'b0 || last_a !== 1'b0 || ready_a !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_idle valid=%b serial=%b last=%b ready=%b expected 0 0 0 1", valid_a, serial_a, last_a, ready_a);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_bits[$];
    exp_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
`ifdef PISO_PARITY_EN
    exp_bits.push_back(1'b1);
`endif
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b0);
`ifdef PISO_PARITY_EN
    exp_bits.push_back(1'b0);
`endif
    load_a = 1'b1;
    data_a = 4'b1011;
    @(negedge clk);
    data_a = 4'b0110;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == FRAME) load_a = 1'b0;
      tests_run++;
      if (valid_a !== 1'b1 || serial_a !== exp_bits[i] ||
          last_a !== (i == FRAME - 1 || i == 2 * FRAME - 1)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_bit%0d valid=%b serial=%b last=%b expected 1 %b %b",
                 i, valid_a, serial_a, last_a, exp_bits[i], (i == FRAME - 1 || i == 2 * FRAME - 1));
      end
      @(negedge clk);
    end
    tests_run++;
    if (valid_a !== 1'b0 || serial_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_idle valid=%b serial=%b expected 0 0", valid_a, serial_a);
    end
  endtask

  task automatic test_ignored_load();
    bit exp_bits[$];
    exp_bits = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef PISO_PARITY_EN
    exp_bits.push_back(1'b1);
`endif
    load_a = 1'b1;
    data_a = 4'b0001;
    @(negedge clk);
    load_a = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 1) begin
        load_a = 1'b1;
        data_a = 4'b1111;
      end
      if (i == 2) load_a = 1'b0;
      tests_run++;
      if (valid_a !== 1'b1 || serial_a !== exp_bits[i] || last_a !== (i == FRAME - 1)) begin
        tests_failed++;
        $display("[TB] FAIL ignore_bit%0d valid=%b serial=%b last=%b expected 1 %b %b",
                 i, valid_a, serial_a, last_a, exp_bits[i], (i == FRAME - 1));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (valid_a !== 1'b0 || serial_a !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ignore_idle%0d valid=%b serial=%b expected 0 0", i, valid_a, serial_a);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit exp_bits[$];
    exp_bits = '{1'b1, 1'b0, 1'b1};
    load_a = 1'b1;
    data_a = 4'b1010;
    @(negedge clk);
    load_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (valid_a !== 1'b1 || serial_a !== exp_bits[i]) begin
        tests_failed++;
        $display("[TB] FAIL abort_bit%0d valid=%b serial=%b expected 1 %b", i, valid_a, serial_a, exp_bits[i]);
      end
      if (i < 2) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (valid_a !== 1'b0 || last_a !== 1'b0 || serial_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_async valid=%b last=%b serial=%b expected 0 0 0", valid_a, last_a, serial_a);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (ready_a !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_ready ready=%b expected 1", ready_a);
    end
    for (int i = 0; i < FRAME + 1; i++) begin
      @(negedge clk);
      tests_run++;
      if (valid_a !== 1'b0 || last_a !== 1'b0 || serial_a !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL abort_quiet%0d valid=%b last=%b serial=%b expected 0 0 0", i, valid_a, last_a, serial_a);
      end
    end
  endtask

  task automatic test_lsb_first();
    bit exp_bits[$];
    exp_bits = '{1'b1, 1'b1, 1'b0, 1'b1};
`ifdef PISO_PARITY_EN
    exp_bits.push_back(1'b1);
`endif
    load_b = 1'b1;
    data_b = 4'b1011;
    @(negedge clk);
    load_b = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      tests_run++;
      if (valid_b !== 1'b1 || serial_b !== exp_bits[i] || last_b !== (i == FRAME - 1)) begin
        tests_failed++;
        $display("[TB] FAIL lsb_bit%0d valid=%b serial=%b last=%b expected 1 %b %b",
                 i, valid_b, serial_b, last_b, exp_bits[i], (i == FRAME - 1));
      end
      @(negedge clk);
    end
    tests_run++;
    if (valid_b !== 1'b0 || serial_b !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lsb_idle valid=%b serial=%b expected 0 0", valid_b, serial_b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_frame();
    test_lsb_first();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
